// File: rtl/acc_dummy_gen_pkg.sv
// ---------------------------------------------------------------------------
// acc_dummy_gen_pkg
// Shared types for the dummy accelerator generator.
//   state_t : batch FSM states (idle, capture input, processing wait, emit)
//   mode_t  : output transform applied to each emitted word
// ---------------------------------------------------------------------------
package acc_dummy_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_WAIT    = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_ADDK = 2'd2,
    MODE_ZERO = 2'd3
  } mode_t;

endpackage

// File: rtl/acc_dummy_gen_buf.sv
// ---------------------------------------------------------------------------
// acc_dummy_gen_buf
// Capture buffer: DEPTH x DATA_W storage, one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data, follows raddr combinationally
// ---------------------------------------------------------------------------
module acc_dummy_gen_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Plain storage without reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/acc_dummy_gen.sv
// ---------------------------------------------------------------------------
// acc_dummy_gen
// Dummy accelerator: consumes a batch of serialization_ratio words, waits
// wait_cycles cycles, then produces deserialization_ratio words built by
// cycling through the captured words and applying a mode transform.
//
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   serialization_ratio     : words consumed per batch (0 behaves as 1)
//   deserialization_ratio   : words produced per batch (0 skips emission)
//   wait_cycles             : processing delay between capture and emit
//   mode                    : 0 pass, 1 invert, 2 add index k, 3 all-zero
//   consumer_valid/ready/data : input stream (ready only while capturing)
//   producer_valid/ready/data : output stream
//   busy                    : high whenever a batch is in progress
//   batch_count             : completed batches, only when the
//                             ACC_DUMMY_GEN_STATS_EN macro is defined
//
// Batch configuration is latched at batch start; input changes while a
// batch is running are ignored.
// ---------------------------------------------------------------------------
module acc_dummy_gen
  import acc_dummy_gen_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8,
  parameter int RATIO_W = 16,
  parameter int WAIT_W  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RATIO_W-1:0] serialization_ratio,
  input  logic [RATIO_W-1:0] deserialization_ratio,
  input  logic [WAIT_W-1:0]  wait_cycles,
  input  logic [1:0]         mode,
  input  logic               consumer_valid,
  output logic               consumer_ready,
  input  logic [DATA_W-1:0]  consumer_data,
  output logic               producer_valid,
  input  logic               producer_ready,
  output logic [DATA_W-1:0]  producer_data,
  output logic               busy
`ifdef ACC_DUMMY_GEN_STATS_EN
  ,
  output logic [31:0]        batch_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [RATIO_W-1:0] DEPTH_R = RATIO_W'(DEPTH);

  state_t state, state_next;

  logic [RATIO_W-1:0] ser_lat;
  logic [RATIO_W-1:0] deser_lat;
  logic [WAIT_W-1:0]  wait_lat;
  mode_t              mode_lat;

  logic [RATIO_W-1:0] in_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [RATIO_W-1:0] out_cnt;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   last_idx;

  logic [RATIO_W-1:0] ser_in_eff;
  logic [IDX_W-1:0]   last_idx_in;
  logic               xfer_in;
  logic               xfer_out;
  logic               last_in;
  logic               last_wait;
  logic               last_out;
  logic               buf_we;
  logic [DATA_W-1:0]  rd_data;

  assign xfer_in  = consumer_valid & consumer_ready;
  assign xfer_out = producer_valid & producer_ready;

  // ser_lat is never zero once latched, so the "minus one" compare is safe
  // and counters stop at the ratio instead of wrapping.
  assign last_in   = (in_cnt == (ser_lat - RATIO_W'(1)));
  assign last_wait = (wait_cnt == (wait_lat - WAIT_W'(1)));
  assign last_out  = (out_cnt == (deser_lat - RATIO_W'(1)));

  // Last valid read index is min(captured, DEPTH) - 1, fixed at batch start
  // so emission can cycle through the buffer without a modulo operator.
  assign ser_in_eff  = (serialization_ratio == '0) ? RATIO_W'(1) : serialization_ratio;
  assign last_idx_in = (ser_in_eff >= DEPTH_R) ? IDX_W'(DEPTH - 1)
                                               : IDX_W'(ser_in_eff - RATIO_W'(1));

  // Only the first DEPTH words of a batch are stored; the rest are consumed
  // and dropped.
  assign buf_we = xfer_in & (in_cnt < DEPTH_R);

  acc_dummy_gen_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (in_cnt[IDX_W-1:0]),
    .wdata (consumer_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero wait skips S_WAIT and a zero deserialization
  // ratio skips S_EMIT.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (consumer_valid) begin
          state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (xfer_in && last_in) begin
          if (wait_lat != '0) begin
            state_next = S_WAIT;
          end else if (deser_lat != '0) begin
            state_next = S_EMIT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (last_wait) begin
          state_next = (deser_lat != '0) ? S_EMIT : S_IDLE;
        end
      end
      S_EMIT: begin
        if (xfer_out && last_out) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs. producer_data depends only on registered state, so it holds
  // steady while the consumer stalls.
  always_comb begin
    consumer_ready = (state == S_CAPTURE);
    producer_valid = (state == S_EMIT);
    busy           = (state != S_IDLE);
    producer_data  = '0;
    if (state == S_EMIT) begin
      case (mode_lat)
        MODE_PASS: producer_data = rd_data;
        MODE_INV:  producer_data = ~rd_data;
        MODE_ADDK: producer_data = rd_data + DATA_W'(out_cnt);
        MODE_ZERO: producer_data = '0;
        default:   producer_data = '0;
      endcase
    end
  end

  // Batch configuration and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_lat   <= '0;
      deser_lat <= '0;
      wait_lat  <= '0;
      mode_lat  <= MODE_PASS;
      last_idx  <= '0;
      in_cnt    <= '0;
      wait_cnt  <= '0;
      out_cnt   <= '0;
      rd_idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (consumer_valid) begin
            ser_lat   <= ser_in_eff;
            deser_lat <= deserialization_ratio;
            wait_lat  <= wait_cycles;
            mode_lat  <= mode_t'(mode);
            last_idx  <= last_idx_in;
            in_cnt    <= '0;
            wait_cnt  <= '0;
            out_cnt   <= '0;
            rd_idx    <= '0;
          end
        end
        S_CAPTURE: begin
          if (xfer_in) begin
            in_cnt <= in_cnt + RATIO_W'(1);
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_EMIT: begin
          if (xfer_out) begin
            out_cnt <= out_cnt + RATIO_W'(1);
            rd_idx  <= (rd_idx == last_idx) ? '0 : rd_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ACC_DUMMY_GEN_STATS_EN
  // Counts every return to idle from a running batch, including batches
  // that skip emission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_count <= '0;
    end else if ((state != S_IDLE) && (state_next == S_IDLE)) begin
      batch_count <= batch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_dummy_gen.sv
// ---------------------------------------------------------------------------
// tb_acc_dummy_gen
// Self-checking bench for acc_dummy_gen with default parameters.
// ---------------------------------------------------------------------------
module tb_acc_dummy_gen;

  localparam int DATA_W  = 64;
  localparam int DEPTH   = 8;
  localparam int RATIO_W = 16;
  localparam int WAIT_W  = 14;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [RATIO_W-1:0] serialization_ratio = '0;
  logic [RATIO_W-1:0] deserialization_ratio = '0;
  logic [WAIT_W-1:0]  wait_cycles = '0;
  logic [1:0]         mode = '0;
  logic               consumer_valid = 1'b0;
  logic               consumer_ready;
  logic [DATA_W-1:0]  consumer_data = '0;
  logic               producer_valid;
  logic               producer_ready = 1'b1;
  logic [DATA_W-1:0]  producer_data;
  logic               busy;
`ifdef ACC_DUMMY_GEN_STATS_EN
  logic [31:0]        batch_count;
  int                 expBatches = 0;
`endif

  acc_dummy_gen #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RATIO_W (RATIO_W),
    .WAIT_W  (WAIT_W)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .serialization_ratio   (serialization_ratio),
    .deserialization_ratio (deserialization_ratio),
    .wait_cycles           (wait_cycles),
    .mode                  (mode),
    .consumer_valid        (consumer_valid),
    .consumer_ready        (consumer_ready),
    .consumer_data         (consumer_data),
    .producer_valid        (producer_valid),
    .producer_ready        (producer_ready),
    .producer_data         (producer_data),
    .busy                  (busy)
`ifdef ACC_DUMMY_GEN_STATS_EN
    ,
    .batch_count           (batch_count)
`endif
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic [DATA_W-1:0] expQ[$];
  logic [DATA_W-1:0] gotQ[$];
  logic [DATA_W-1:0] wq[$];
  int cycle = 0;
  int consumedCnt = 0;
  int producedCnt = 0;
  int lastXferCycle = -1;
  int firstPvCycle = -1;
  logic prevHold = 1'b0;
  logic [DATA_W-1:0] prevData = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] gotAt(input int i);
    if (i < gotQ.size()) return gotQ[i];
    return 'x;
  endfunction

  // Compare process: every accepted output word is checked against the model
  // queue, and a stalled word must not change until it is accepted.
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      prevHold = 1'b0;
    end else begin
      if (consumer_valid && consumer_ready) begin
        consumedCnt++;
        lastXferCycle = cycle;
      end
      if (producer_valid) begin
        if (firstPvCycle < 0) firstPvCycle = cycle;
        if (prevHold) checkOutput("hold_stable", producer_data, prevData);
        if (producer_ready) begin
          producedCnt++;
          gotQ.push_back(producer_data);
          if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_output: got %0h expected no output", producer_data);
          end else begin
            checkOutput("stream_data", producer_data, expQ.pop_front());
          end
        end
      end
      prevHold = producer_valid && !producer_ready;
      prevData = producer_data;
    end
  end

  // Runs one batch: builds the expected output stream from the batch rules,
  // feeds the words, optionally stalls the producer side, and waits for idle.
  task automatic applyStimulus(input int ser, input int deser, input int waitC, input int md,
                               input logic [DATA_W-1:0] words[$], input bit doStall);
    int serEff, lim, idx, budget, stallLeft, emitCycles;
    bit x, b, pv, stalled;
    logic [DATA_W-1:0] w;
    serEff = (ser == 0) ? 1 : ser;
    lim = (serEff < DEPTH) ? serEff : DEPTH;
    for (int k = 0; k < deser; k++) begin
      w = words[k % lim];
      case (md)
        0: w = w;
        1: w = ~w;
        2: w = w + 64'(k);
        default: w = '0;
      endcase
      expQ.push_back(w);
    end
    gotQ.delete();
    consumedCnt = 0;
    producedCnt = 0;
    firstPvCycle = -1;
    lastXferCycle = -1;

    @(posedge clk); #1;
    serialization_ratio   = RATIO_W'(ser);
    deserialization_ratio = RATIO_W'(deser);
    wait_cycles           = WAIT_W'(waitC);
    mode                  = 2'(md);
    consumer_valid        = 1'b1;
    consumer_data         = words[0];
    // Idle latches the configuration on this edge; then scramble inputs.
    @(posedge clk); #1;
    serialization_ratio   = RATIO_W'(ser + 3);
    deserialization_ratio = RATIO_W'(deser + 5);
    wait_cycles           = WAIT_W'(waitC + 7);
    mode                  = mode ^ 2'b11;

    idx = 0;
    budget = 0;
    while (idx < serEff && budget < 1000) begin
      @(negedge clk);
      x = consumer_valid && consumer_ready;
      @(posedge clk); #1;
      budget++;
      if (x) begin
        idx++;
        consumer_data = (idx < serEff) ? words[idx] : 64'hDEAD_BEEF_0BAD_F00D;
      end
    end
    if (idx < serEff) checkOutput("capture_timeout", 64'(idx), 64'(serEff));
    if (deser == 0) consumer_valid = 1'b0;

    stallLeft = 0;
    emitCycles = 0;
    stalled = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      b = busy;
      pv = producer_valid;
      if (pv) emitCycles++;
      @(posedge clk); #1;
      budget++;
      if (pv) consumer_valid = 1'b0;
      if (doStall && !stalled && emitCycles == 2) begin
        producer_ready = 1'b0;
        stallLeft = 5;
        stalled = 1'b1;
      end else if (stallLeft > 0) begin
        stallLeft--;
        if (stallLeft == 0) producer_ready = 1'b1;
      end
    end while (b && budget < 2000);
    if (b) checkOutput("batch_timeout", 64'(b), 64'd0);
    consumer_valid = 1'b0;
    producer_ready = 1'b1;

    checkOutput("consumed_words", 64'(consumedCnt), 64'(serEff));
    checkOutput("produced_words", 64'(producedCnt), 64'(deser));
    checkOutput("model_drained", 64'(expQ.size()), 64'd0);
    expQ.delete();
    if (deser > 0) checkOutput("emit_latency", 64'(firstPvCycle - lastXferCycle), 64'(waitC + 1));
    checkOutput("idle_after_batch", {63'b0, busy}, 64'd0);
`ifdef ACC_DUMMY_GEN_STATS_EN
    expBatches++;
    checkOutput("batch_count", {32'b0, batch_count}, 64'(expBatches));
`endif
  endtask

  initial begin
    logic [63:0] lit[5];

    // Reset state
    #3;
    checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_consumer_ready", {63'b0, consumer_ready}, 64'd0);
    checkOutput("rst_producer_valid", {63'b0, producer_valid}, 64'd0);
    checkOutput("rst_producer_data", producer_data, 64'd0);
`ifdef ACC_DUMMY_GEN_STATS_EN
    checkOutput("rst_batch_count", {32'b0, batch_count}, 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic pass-through, wait 3
    wq.delete();
    wq.push_back(64'hAAAA_0000_0000_000A);
    wq.push_back(64'hBBBB_0000_0000_000B);
    wq.push_back(64'hCCCC_0000_0000_000C);
    wq.push_back(64'hDDDD_0000_0000_000D);
    applyStimulus(4, 4, 3, 0, wq, 1'b0);
    checkOutput("pass_lit0", gotAt(0), 64'hAAAA_0000_0000_000A);
    checkOutput("pass_lit3", gotAt(3), 64'hDDDD_0000_0000_000D);

    // Add-k with wrap-around over two captured words
    wq.delete();
    wq.push_back(64'd10);
    wq.push_back(64'd20);
    applyStimulus(2, 5, 2, 2, wq, 1'b0);
    lit = '{64'd10, 64'd21, 64'd12, 64'd23, 64'd14};
    for (int i = 0; i < 5; i++) checkOutput("addk_lit", gotAt(i), lit[i]);

    // More words than buffer entries, invert
    wq.delete();
    for (int i = 0; i < 12; i++) wq.push_back(64'h1000 + 64'(i) * 64'h111);
    applyStimulus(12, 8, 2, 1, wq, 1'b0);
    checkOutput("inv_lit0", gotAt(0), ~64'h1000);
    checkOutput("inv_lit7", gotAt(7), ~64'h1777);

    // Zero wait, zero deserialization: skip straight back to idle
    wq.delete();
    wq.push_back(64'h1234);
    applyStimulus(1, 0, 0, 0, wq, 1'b0);

    // Producer stall for 5 cycles mid-emission
    wq.delete();
    wq.push_back(64'h100);
    wq.push_back(64'h200);
    wq.push_back(64'h300);
    applyStimulus(3, 6, 1, 2, wq, 1'b1);
    checkOutput("stall_lit5", gotAt(5), 64'h305);

    // Serialization ratio 0 behaves as 1
    wq.delete();
    wq.push_back(64'h5A5A);
    applyStimulus(0, 3, 2, 0, wq, 1'b0);
    checkOutput("ser0_lit2", gotAt(2), 64'h5A5A);

    // Skip emission after a non-zero wait
    wq.delete();
    wq.push_back(64'h1);
    wq.push_back(64'h2);
    applyStimulus(2, 0, 4, 3, wq, 1'b0);

    // All-zero mode, zero wait
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(64'hFFFF_0000 + 64'(i));
    applyStimulus(5, 3, 0, 3, wq, 1'b0);
    checkOutput("zero_lit1", gotAt(1), 64'd0);

    // Reset pulse in the middle of capture
    @(posedge clk); #1;
    serialization_ratio   = 16'd8;
    deserialization_ratio = 16'd4;
    wait_cycles           = 14'd2;
    mode                  = 2'd0;
    consumer_valid        = 1'b1;
    consumer_data         = 64'h7777;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {63'b0, busy}, 64'd0);
    checkOutput("midrst_consumer_ready", {63'b0, consumer_ready}, 64'd0);
    checkOutput("midrst_producer_valid", {63'b0, producer_valid}, 64'd0);
    checkOutput("midrst_producer_data", producer_data, 64'd0);
`ifdef ACC_DUMMY_GEN_STATS_EN
    expBatches = 0;
    checkOutput("midrst_batch_count", {32'b0, batch_count}, 64'd0);
`endif
    @(posedge clk); #1;
    consumer_valid = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("postrst_busy", {63'b0, busy}, 64'd0);
    checkOutput("postrst_producer_valid", {63'b0, producer_valid}, 64'd0);

    // Normal batch after recovering from reset
    wq.delete();
    wq.push_back(64'h0F0F);
    wq.push_back(64'hF0F0);
    applyStimulus(2, 2, 1, 1, wq, 1'b0);
    checkOutput("postrst_lit1", gotAt(1), ~64'hF0F0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
